// File: rtl/conv_1x1_ofm_writer_pkg.sv
// Shared types and requantization helper for the 1x1 convolution OFM writer.
// OFM_RELU_EN (see top) selects the unsigned saturation range via the relu argument.
package conv_1x1_ofm_writer_pkg;

  localparam int unsigned NumPeDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } ofm_state_e;

  // acc arrives sign-extended to 64 bits so any accumulator width up to 64 fits.
  function automatic logic [7:0] requant_sat(input logic signed [63:0] acc,
                                             input logic [4:0]         shift,
                                             input logic               relu);
    logic signed [63:0] t;
    t = acc >>> shift;
    if (t > 64'sd127) begin
      return 8'h7f;
    end else if (relu && (t < 64'sd0)) begin
      return 8'h00;
    end else if (t < -64'sd128) begin
      return 8'h80;
    end
    return t[7:0];
  endfunction

endpackage

// File: rtl/conv_1x1_ofm_writer_fifo.sv
// Synchronous packed-word FIFO between the lane packer and the OFM write port.
module conv_1x1_ofm_writer_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/conv_1x1_ofm_writer.sv
// Collects per-lane PE results, requantizes to int8, packs them and writes OFM words.
// Define OFM_RELU_EN to clamp negative results to zero before packing.
module conv_1x1_ofm_writer
  import conv_1x1_ofm_writer_pkg::*;
#(
  parameter int unsigned NUM_PE     = NumPeDefault,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cal_start_i,
  input  logic [7:0]              num_filter_i,
  input  logic [15:0]             num_pixel_i,
  input  logic [4:0]              out_shift_i,
  input  logic [NUM_PE-1:0]       pe_finish_i,
  input  logic [NUM_PE*ACC_W-1:0] pe_result_i,
  output logic                    pe_stall_o,
  output logic                    ofm_wr_en_o,
  input  logic                    ofm_wr_ready_i,
  output logic [ADDR_W-1:0]       ofm_addr_o,
  output logic [8*NUM_PE-1:0]     ofm_wdata_o,
  output logic                    busy_o,
  output logic                    done_o
);

`ifdef OFM_RELU_EN
  localparam logic Relu = 1'b1;
`else
  localparam logic Relu = 1'b0;
`endif
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  ofm_state_e               state_q, state_d;
  logic [7:0]               num_filter_q, filter_cnt_q, filter_cnt_d;
  logic [15:0]              num_pixel_q, pixel_cnt_q, pixel_cnt_d;
  logic [4:0]               shift_q;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [NUM_PE-1:0][7:0]   lane_q, lane_d;
  logic [NUM_PE-1:0]        mask_q, mask_set, fin_acc;
  logic [8*NUM_PE-1:0]      word_q, fifo_rdata;
  logic                     word_vld_q, grp_done, stall, flush, accept;
  logic                     fifo_empty, last_filt, last_pix;
  logic [CntW-1:0]          fifo_cnt;

  always_comb begin
    stall   = (fifo_cnt >= CntW'(FIFO_DEPTH - 1)) || (state_q != StRun);
    fin_acc = pe_finish_i & {NUM_PE{~stall}};
    lane_d  = lane_q;
    for (int i = 0; i < NUM_PE; i++) begin
      if (fin_acc[i]) begin
        lane_d[i] = requant_sat(64'($signed(pe_result_i[i*ACC_W +: ACC_W])), shift_q, Relu);
      end
    end
    mask_set = mask_q | fin_acc;
    grp_done = &mask_set;
  end

  // A completed group is staged one cycle in word_q before entering the FIFO.
  conv_1x1_ofm_writer_fifo #(
    .Width(8 * NUM_PE),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (flush),
    .push_i (word_vld_q),
    .wdata_i(word_q),
    .pop_i  (accept),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

  assign ofm_wr_en_o = ~fifo_empty & (state_q == StRun);
  assign accept      = ofm_wr_en_o & ofm_wr_ready_i;
  assign ofm_wdata_o = ofm_wr_en_o ? fifo_rdata : '0;
  assign ofm_addr_o  = addr_q;
  assign pe_stall_o  = stall;
  assign busy_o      = (state_q == StRun);
  assign done_o      = (state_q == StDone);
  assign last_filt   = (filter_cnt_q == num_filter_q - 8'(NUM_PE));
  assign last_pix    = (pixel_cnt_q == num_pixel_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    filter_cnt_d = filter_cnt_q;
    pixel_cnt_d  = pixel_cnt_q;
    flush        = 1'b0;
    case (state_q)
      StIdle: begin
        if (cal_start_i) begin
          state_d      = StRun;
          addr_d       = '0;
          filter_cnt_d = '0;
          pixel_cnt_d  = '0;
          flush        = 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(NUM_PE);
          if (last_filt) begin
            filter_cnt_d = '0;
            pixel_cnt_d  = pixel_cnt_q + 16'd1;
            if (last_pix) state_d = StDone;
          end else begin
            filter_cnt_d = filter_cnt_q + 8'(NUM_PE);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      num_filter_q <= '0;
      num_pixel_q  <= '0;
      shift_q      <= '0;
      filter_cnt_q <= '0;
      pixel_cnt_q  <= '0;
      addr_q       <= '0;
      lane_q       <= '0;
      mask_q       <= '0;
      word_q       <= '0;
      word_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      filter_cnt_q <= filter_cnt_d;
      pixel_cnt_q  <= pixel_cnt_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      if (flush) begin
        num_filter_q <= num_filter_i;
        num_pixel_q  <= num_pixel_i;
        shift_q      <= out_shift_i;
        mask_q       <= '0;
        word_vld_q   <= 1'b0;
      end else begin
        mask_q     <= grp_done ? '0 : mask_set;
        word_vld_q <= grp_done;
      end
      if (grp_done) word_q <= lane_d;
    end
  end

endmodule

// File: tb/tb_conv_1x1_ofm_writer.sv
// Self-checking bench for conv_1x1_ofm_writer: vector table, directed corners, random layers.
module tb_conv_1x1_ofm_writer;

  localparam int NUM_PE = 4;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    cal_start = 1'b0;
  logic [7:0]              num_filter = '0;
  logic [15:0]             num_pixel = '0;
  logic [4:0]              out_shift = '0;
  logic [NUM_PE-1:0]       pe_finish = '0;
  logic [NUM_PE*32-1:0]    pe_result = '0;
  logic                    pe_stall, ofm_wr_en, busy, done;
  logic                    ofm_wr_ready = 1'b1;
  logic [31:0]             ofm_addr;
  logic [8*NUM_PE-1:0]     ofm_wdata;

  conv_1x1_ofm_writer #(
    .NUM_PE(NUM_PE), .ACC_W(32), .ADDR_W(32), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cal_start_i(cal_start), .num_filter_i(num_filter),
    .num_pixel_i(num_pixel), .out_shift_i(out_shift), .pe_finish_i(pe_finish),
    .pe_result_i(pe_result), .pe_stall_o(pe_stall), .ofm_wr_en_o(ofm_wr_en),
    .ofm_wr_ready_i(ofm_wr_ready), .ofm_addr_o(ofm_addr), .ofm_wdata_o(ofm_wdata),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

`ifdef OFM_RELU_EN
  localparam longint SatLo = 0;
`else
  localparam longint SatLo = -128;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          exp_addr = 0;
  int          writes_seen = 0;
  int          layer_writes = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requantization from first principles: floor division by 2^sh, then clamp.
  function automatic logic [7:0] ref_byte(input logic [31:0] acc, input int sh);
    longint a, d, q;
    a = longint'($signed(acc));
    d = longint'(1) << sh;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    if (q > 127) q = 127;
    if (q < SatLo) q = SatLo;
    return q[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ofm_wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_layer(input int nf, input int np, input int sh);
    num_filter   = 8'(nf);
    num_pixel    = 16'(np);
    out_shift    = 5'(sh);
    exp_addr     = 0;
    writes_seen  = 0;
    layer_writes = (nf / NUM_PE) * np;
    cal_start    = 1'b1;
    tick();
    cal_start    = 1'b0;
    check("busy_in_run", busy, 1);
  endtask

  // Raises lanes only while not stalled; rnd spreads lanes over several cycles.
  task automatic send_group(input logic [NUM_PE-1:0][31:0] acc, input bit rnd);
    logic [NUM_PE-1:0] pend, sel;
    int guard;
    pend  = '1;
    guard = 0;
    while (pend != '0) begin
      if (!pe_stall) begin
        sel = rnd ? (NUM_PE'($urandom) & pend) : pend;
        if (sel == '0) sel = pend & (~pend + 1'b1);
        pe_finish = sel;
        pe_result = acc;
        pend      = pend & ~sel;
      end
      tick();
      pe_finish = '0;
      guard++;
      if (guard > 500) begin
        check("group_timeout", 0, 1);
        pend = '0;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
    tick();
    check("idle_after_done", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Write-port scoreboard, hold-stability and done-timing checks.
  logic        hold_pend = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] hold_addr, hold_data;
  always @(negedge clk) begin
    if (hold_pend && reset_n) begin
      check("hold_en", ofm_wr_en, 1);
      check("hold_addr", ofm_addr, hold_addr);
      check("hold_data", ofm_wdata, hold_data);
    end
    hold_pend = reset_n && ofm_wr_en && !ofm_wr_ready;
    hold_addr = ofm_addr;
    hold_data = ofm_wdata;
    if (reset_n && ofm_wr_en && ofm_wr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", ofm_wdata, 0);
      end else begin
        check("wdata", ofm_wdata, exp_q.pop_front());
        check("addr", ofm_addr, exp_addr);
      end
      exp_addr += NUM_PE;
      writes_seen++;
    end
    if (reset_n && done) begin
      check("done_after_last", writes_seen, layer_writes);
      check("done_one_cycle", prev_done, 0);
    end
    prev_done = reset_n && done;
  end

  typedef struct {
    logic [NUM_PE-1:0][31:0] acc;
    int                      sh;
    logic [31:0]             exp_s;
    logic [31:0]             exp_r;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [NUM_PE-1:0][31:0] acc;
    logic [31:0]             w;
    int                      nf, np, sh;

    // acc packing order: {lane3, lane2, lane1, lane0}
    tbl[0] = '{{32'h0, 32'h150, 32'hFFFFF000, 32'h7FFFFFFF}, 4, 32'h0015807F, 32'h0015007F};
    tbl[1] = '{{32'd4, 32'd3, 32'd2, 32'd1}, 0, 32'h04030201, 32'h04030201};
    tbl[2] = '{{32'hFFFFFF7F, 32'd128, 32'd127, 32'hFFFFFFFF}, 0, 32'h807F7FFF, 32'h007F7F00};
    tbl[3] = '{{32'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000}, 31, 32'h00FF00FF, 32'h0};
    tbl[4] = '{{32'd256, 32'd255, 32'hFFFFFED4, 32'd200}, 1, 32'h7F7F8064, 32'h7F7F0064};
    tbl[5] = '{{32'hFFFFFFFF, 32'h10000, 32'hFFFFEDCC, 32'h1234}, 8, 32'hFF7FED12, 32'h007F0012};

    // Reset state
    repeat (3) tick();
    check("rst_wr_en", ofm_wr_en, 0);
    check("rst_addr", ofm_addr, 0);
    check("rst_wdata", ofm_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall_idle", pe_stall, 1);
    reset_n = 1'b1;
    tick();

    // Single group, all lanes same cycle; latency and done timing
    start_layer(4, 1, 0);
    exp_q.push_back(32'h04030201);
    pe_result = {32'd4, 32'd3, 32'd2, 32'd1};
    pe_finish = '1;
    tick();
    pe_finish = '0;
    check("lat_en_cycle1", ofm_wr_en, 0);
    tick();
    check("lat_en_cycle2", ofm_wr_en, 1);
    check("t1_addr", ofm_addr, 0);
    check("t1_data", ofm_wdata, 32'h04030201);
    tick();
    check("t1_done", done, 1);
    check("t1_busy_done", busy, 0);
    tick();
    check("t1_done_clear", done, 0);

    // Lanes arriving on cycles 0,3,1,5
    start_layer(4, 1, 0);
    exp_q.push_back(32'h281E140A);
    pe_result = {32'd40, 32'd30, 32'd20, 32'd10};
    for (int c = 0; c <= 5; c++) begin
      pe_finish[0] = (c == 0);
      pe_finish[1] = (c == 3);
      pe_finish[2] = (c == 1);
      pe_finish[3] = (c == 5);
      tick();
      if (c == 4) check("t2_no_early_write", ofm_wr_en, 0);
    end
    pe_finish = '0;
    check("t2_en_lat1", ofm_wr_en, 0);
    tick();
    check("t2_en_lat2", ofm_wr_en, 1);
    check("t2_data", ofm_wdata, 32'h281E140A);
    wait_done();

    // Requantization/saturation vector table
    for (int v = 0; v < 6; v++) begin
      start_layer(4, 1, tbl[v].sh);
`ifdef OFM_RELU_EN
      exp_q.push_back(tbl[v].exp_r);
`else
      exp_q.push_back(tbl[v].exp_s);
`endif
      send_group(tbl[v].acc, 1'b0);
      wait_done();
    end

    // Multi-filter, multi-pixel layer: 6 writes, addresses 0..20
    start_layer(8, 3, 0);
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < NUM_PE; i++) acc[i] = 32'(g * 16 + i);
      for (int i = 0; i < NUM_PE; i++) w[8*i +: 8] = ref_byte(acc[i], 0);
      exp_q.push_back(w);
      send_group(acc, 1'b0);
    end
    wait_done();
    check("t4_final_addr", ofm_addr, 24);

    // Backpressure: ready low for 20 cycles
    start_layer(4, 4, 2);
    ofm_wr_ready = 1'b0;
    fork
      begin
        for (int g = 0; g < 4; g++) begin
          logic [NUM_PE-1:0][31:0] a5;
          logic [31:0] w5;
          for (int i = 0; i < NUM_PE; i++) a5[i] = 32'(100 * g + 7 * i) - 32'd150;
          for (int i = 0; i < NUM_PE; i++) w5[8*i +: 8] = ref_byte(a5[i], 2);
          exp_q.push_back(w5);
          send_group(a5, 1'b1);
        end
      end
      begin
        repeat (20) tick();
        check("t5_stall_full", pe_stall, 1);
        check("t5_en_waiting", ofm_wr_en, 1);
        check("t5_addr_held", ofm_addr, 0);
        ofm_wr_ready = 1'b1;
      end
    join
    wait_done();

    // Reset mid-RUN with a partial mask, then restart
    start_layer(8, 2, 0);
    pe_result = {32'd9, 32'd9, 32'd9, 32'd9};
    pe_finish = 4'b0011;
    tick();
    pe_finish = '0;
    reset_n   = 1'b0;
    #1;
    check("t6_rst_en", ofm_wr_en, 0);
    check("t6_rst_addr", ofm_addr, 0);
    check("t6_rst_wdata", ofm_wdata, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    tick();
    reset_n = 1'b1;
    tick();
    start_layer(4, 1, 0);
    exp_q.push_back(32'h44332211);
    pe_result = {32'h44, 32'h33, 32'h22, 32'h11};
    pe_finish = 4'b1100;
    tick();
    pe_finish = '0;
    repeat (4) begin
      tick();
      check("t6_mask_cleared", ofm_wr_en, 0);
    end
    pe_finish = 4'b0011;
    tick();
    pe_finish = '0;
    wait_done();

    // Random layers, random lane order and random ready
    rand_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      nf = NUM_PE * $urandom_range(1, 3);
      np = $urandom_range(1, 4);
      sh = $urandom_range(0, 16);
      start_layer(nf, np, sh);
      for (int g = 0; g < (nf / NUM_PE) * np; g++) begin
        for (int i = 0; i < NUM_PE; i++) begin
          acc[i] = ($urandom_range(0, 1) != 0) ? $urandom
                                               : 32'($urandom_range(0, 4000)) - 32'd2000;
          w[8*i +: 8] = ref_byte(acc[i], sh);
        end
        exp_q.push_back(w);
        send_group(acc, 1'b1);
      end
      wait_done();
    end
    rand_ready   = 1'b0;
    ofm_wr_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
